des_key_schedule: RTL and testbench
===================================

// Module: des_key_schedule
// PURPOSE
//  Sequential DES round-key generator; sits directly upstream of the Feistel round stage
//  and supplies one 48-bit subkey per round on a valid/ready stream.
//  Loads a 64-bit key, applies PC-1, then rotates C/D and applies PC-2 once per round.
//  Emits K1..K16 for encryption, or K16..K1 for decryption.
// PARAMETERS
//  none -- DES round count (16), PC-1/PC-2 tables and shift schedule are fixed constants
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  key           in   64  [0:63] DES key, bit 0 = FIPS bit 1; parity bits 7,15,..,63 ignored
//  decrypt       in   1   0 = emit K1..K16, 1 = emit K16..K1; sampled with start
//  start         in   1   load request; accepted only when start & ready
//  ready         out  1   1 in IDLE (can accept start)
//  subkey_valid  out  1   subkey/round_idx/last are valid
//  subkey_ready  in   1   consumer (round stage) accepts current subkey
//  subkey        out  48  [0:47] PC-2(C,D) of current round
//  round_idx     out  4   0..15, index of emitted round (0 = first emitted)
//  last          out  1   round_idx==15 & subkey_valid
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ready=1, subkey_valid=0, round_idx=0, C=D=0.
//   subkey is a function of C/D, so it is PC-2 of zeros (= 0) during reset.
//  FSM: IDLE, RUN.
//  IDLE: ready=1, subkey_valid=0.
//   On start: (C,D) <= PC1(key), with the initial rotation applied; round_idx <= 0;
//   mode <= decrypt; go to RUN.
//   Initial rotation: encrypt = rotl by 1; decrypt = none, since C0D0 == C16D16.
//  RUN: ready=0, subkey_valid=1, subkey = PC2(C,D), combinational from registers.
//   Handshake: a transfer occurs on subkey_valid & subkey_ready.
//   Outputs stay stable while subkey_ready=0; there is no timeout.
//   On transfer with round_idx<15: round_idx++, and C and D are each rotated by shift(round_idx+1).
//    encrypt: rotl, schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1
//    decrypt: rotr, schedule 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (entry 0 is the initial rotation)
//   On transfer with round_idx==15: go to IDLE, subkey_valid=0, round_idx=0.
//  Rotation is on each 28-bit half independently (wrap within the half).
//  start is ignored while in RUN (no restart, no abort).
//  Latency: start accepted at edge T -> K_first valid after T.
//   With subkey_ready held 1: 16 subkeys on 16 consecutive cycles; ready=1 again after the
//   16th transfer edge, so a back-to-back start costs 1 idle cycle.
//  Reset asserted mid-run: immediate return to the reset state; the partial sequence is discarded.
//  key and decrypt are only sampled at the start transfer; changes during RUN have no effect.
// STRUCTURE
//  des_pkg (shared with the round datapath):
//   - PC1 table (56 entries), PC2 table (48 entries)
//   - shift schedule constants
//   - localparam DES_ROUNDS = 16
//  Sub-module des_pc2: combinational 56->48 permutation; the round stage reuses nothing from it.
//  This block: FSM, 28-bit C and D registers, 4-bit round counter, rotate muxes (0/1/2, left/right).
// TESTING
//  1. key=133457799BBCDFF1, decrypt=0, subkey_ready=1:
//     K1=1B02EFFC7072, K16=CB3D8B0E17F5, last on the 16th, ready=1 afterwards.
//  2. Same key, decrypt=1: first subkey=CB3D8B0E17F5, 16th=1B02EFFC7072;
//     sequence is the exact reverse of test 1.
//  3. Backpressure: random subkey_ready gaps.
//     -> subkey/round_idx stable while stalled, no round skipped or duplicated, exactly 16 transfers.
//  4. start pulsed during RUN (round 5) with a different key -> ignored; sequence matches test 1.
//  5. rst_n low at round 8 -> valid=0 and ready=1 immediately;
//     new start yields a correct full sequence.
//  6. Parity-bit independence: key 123456789ABCDEF0 vs same key with all parity bits flipped
//     -> identical 16 subkeys; compare all rounds against a C/Python reference model.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants: PC-1/PC-2 tables, key-schedule shift amounts and C/D helpers.
// Bit numbering: vector MSB corresponds to FIPS bit 1.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ks_state_e;

  localparam logic [5:0] PC1_TAB [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Entry 0 of the decrypt schedule is 0 because C0D0 already equals C16D16.
  localparam logic [1:0] SHIFT_ENC [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
  localparam logic [1:0] SHIFT_DEC [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] cd;
    cd = '0;
    for (int j = 0; j < 56; j++) begin
      cd[6'(55 - j)] = k[6'(7'd64 - {1'b0, PC1_TAB[j]})];
    end
    return cd;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt,
                                        input logic right);
    logic [27:0] r;
    case (amt)
      2'd1:    r = right ? {x[0], x[27:1]}   : {x[26:0], x[27]};
      2'd2:    r = right ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES PC-2 compression permutation: 56-bit C||D to 48-bit round subkey.
import des_pkg::*;

module des_pc2 (
  input  logic [55:0] cd_i,
  output logic [47:0] k_o
);

  // Pure wiring permutation; table entries are FIPS 1-based positions.
  always_comb begin
    k_o = '0;
    for (int j = 0; j < 48; j++) begin
      k_o[6'(47 - j)] = cd_i[6'(7'd56 - {1'b0, PC2_TAB[j]})];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: one 48-bit subkey per round on a valid/ready stream,
// K1..K16 for encryption or K16..K1 for decryption.
import des_pkg::*;

module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        start,
  output logic        ready,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        last
);

  localparam logic [3:0] LAST_ROUND = 4'(DES_ROUNDS - 1);

  ks_state_e   state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [55:0] cd_load_s;
  logic [1:0]  shift_amt_s;
  logic        unused_parity_s;

  assign unused_parity_s = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8], key[0]};

  // Next-state logic for the IDLE/RUN sequencer and the C/D rotate muxes.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    d_d         = d_q;
    round_d     = round_q;
    mode_d      = mode_q;
    ready_d     = ready_q;
    valid_d     = valid_q;
    last_d      = last_q;
    cd_load_s   = pc1(key);
    shift_amt_s = mode_q ? SHIFT_DEC[round_q + 4'd1] : SHIFT_ENC[round_q + 4'd1];
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          c_d     = rot28(cd_load_s[55:28], decrypt ? 2'd0 : 2'd1, 1'b0);
          d_d     = rot28(cd_load_s[27:0],  decrypt ? 2'd0 : 2'd1, 1'b0);
          round_d = 4'd0;
          mode_d  = decrypt;
          state_d = ST_RUN;
          ready_d = 1'b0;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (subkey_ready) begin
          if (round_q == LAST_ROUND) begin
            state_d = ST_IDLE;
            round_d = 4'd0;
            ready_d = 1'b1;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            c_d     = rot28(c_q, shift_amt_s, mode_q);
            d_d     = rot28(d_q, shift_amt_s, mode_q);
            round_d = round_q + 4'd1;
            last_d  = (round_q == LAST_ROUND - 4'd1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        round_d = 4'd0;
        ready_d = 1'b1;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= 28'd0;
      d_q     <= 28'd0;
      round_q <= 4'd0;
      mode_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i ({c_q, d_q}),
    .k_o  (subkey)
  );

  assign ready        = ready_q;
  assign subkey_valid = valid_q;
  assign round_idx    = round_q;
  assign last         = last_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a FIPS-style reference key schedule.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] key;
  logic        decrypt;
  logic        start;
  logic        ready;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        last;

  int errors = 0;
  int checks = 0;

  logic [47:0] exp_q [16];
  logic [47:0] got   [16];
  logic [47:0] saved [16];

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9,  1, 58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key          (key),
    .decrypt      (decrypt),
    .start        (start),
    .ready        (ready),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .round_idx    (round_idx),
    .last         (last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Textbook key schedule: left rotations only; decryption order is the reversed list.
  task automatic ref_model(input logic [63:0] k, input bit dec);
    bit kb [64];
    bit cc [28];
    bit dd [28];
    bit cd [56];
    bit t0, t1;
    logic [47:0] sub;
    logic [47:0] ek [16];
    for (int i = 0; i < 64; i++) kb[i] = k[63 - i];
    for (int i = 0; i < 28; i++) begin
      cc[i] = kb[PC1_T[i] - 1];
      dd[i] = kb[PC1_T[i + 28] - 1];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH_T[r]; s++) begin
        t0 = cc[0];
        t1 = dd[0];
        for (int i = 0; i < 27; i++) begin
          cc[i] = cc[i + 1];
          dd[i] = dd[i + 1];
        end
        cc[27] = t0;
        dd[27] = t1;
      end
      for (int i = 0; i < 28; i++) begin
        cd[i]      = cc[i];
        cd[i + 28] = dd[i];
      end
      sub = '0;
      for (int j = 0; j < 48; j++) sub = {sub[46:0], cd[PC2_T[j] - 1]};
      ek[r] = sub;
    end
    for (int r = 0; r < 16; r++) exp_q[r] = dec ? ek[15 - r] : ek[r];
  endtask

  // Called at a negedge; returns at the negedge right after the start edge.
  task automatic start_key(input logic [63:0] k, input bit dec);
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout: observed ready=%b expected 1", ready);
    end
    key     = k;
    decrypt = dec;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", 64'(subkey_valid), 64'd1);
    chk("ready_low",   64'(ready),        64'd0);
    chk("first_idx",   64'(round_idx),    64'd0);
  endtask

  task automatic collect(input int stall_pct, input int inject_at, input int abort_at);
    int n, cyc;
    bit stalled, injected;
    logic [47:0] psk;
    logic [3:0]  pidx;
    n = 0; cyc = 0; stalled = 0; injected = 0; psk = '0; pidx = '0;
    while (n < 16 && cyc < 400) begin
      start = 1'b0;
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(subkey_valid), 64'd0);
        chk("abort_ready", 64'(ready),        64'd1);
        chk("abort_idx",   64'(round_idx),    64'd0);
        chk("abort_sk",    64'(subkey),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        subkey_ready = 1'b0;
        return;
      end
      if (stalled) begin
        chk("stall_sk",  64'(subkey),    64'(psk));
        chk("stall_idx", 64'(round_idx), 64'(pidx));
      end
      if (subkey_valid !== 1'b1) begin
        chk("run_valid", 64'(subkey_valid), 64'd1);
        cyc = 400;
      end else begin
        if (n == inject_at && !injected) begin
          key      = ~key;
          decrypt  = ~decrypt;
          start    = 1'b1;
          injected = 1;
        end
        subkey_ready = ($urandom_range(99) >= stall_pct);
        if (subkey_ready) begin
          got[n] = subkey;
          chk($sformatf("idx_r%0d", n),  64'(round_idx), 64'(n));
          chk($sformatf("sk_r%0d", n),   64'(subkey),    64'(exp_q[n]));
          chk($sformatf("last_r%0d", n), 64'(last),      64'(n == 15));
          n++;
          stalled = 0;
        end else begin
          stalled = 1;
          psk     = subkey;
          pidx    = round_idx;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (n < 16) begin
      checks++;
      errors++;
      $error("FAIL transfer_count: observed %0d expected 16", n);
    end
    subkey_ready = 1'b0;
    chk("done_valid", 64'(subkey_valid), 64'd0);
    chk("done_ready", 64'(ready),        64'd1);
    chk("done_last",  64'(last),         64'd0);
  endtask

  initial begin
    logic [63:0] k1, k6, rk;
    bit rd;
    k1 = 64'h133457799BBCDFF1;
    k6 = 64'h123456789ABCDEF0;
    rst_n = 1'b0; start = 1'b0; key = 64'd0; decrypt = 1'b0; subkey_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready),        64'd1);
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_idx",   64'(round_idx),    64'd0);
    chk("rst_sk",    64'(subkey),       64'd0);
    chk("rst_last",  64'(last),         64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer encryption sequence
    ref_model(k1, 1'b0);
    start_key(k1, 1'b0);
    collect(0, -1, -1);
    chk("kat_k1",  64'(got[0]),  64'h1B02EFFC7072);
    chk("kat_k16", 64'(got[15]), 64'hCB3D8B0E17F5);
    for (int r = 0; r < 16; r++) saved[r] = got[r];

    // Decryption is the exact reverse
    ref_model(k1, 1'b1);
    start_key(k1, 1'b1);
    collect(0, -1, -1);
    chk("dec_first", 64'(got[0]),  64'hCB3D8B0E17F5);
    chk("dec_last",  64'(got[15]), 64'h1B02EFFC7072);
    for (int r = 0; r < 16; r++) chk($sformatf("rev_r%0d", r), 64'(got[r]), 64'(saved[15 - r]));

    // Backpressure with random gaps
    ref_model(k1, 1'b0);
    start_key(k1, 1'b0);
    collect(40, -1, -1);

    // start and key/decrypt changes during RUN are ignored
    start_key(k1, 1'b0);
    collect(0, 5, -1);

    // Reset mid-run, then a clean full sequence
    start_key(k1, 1'b0);
    collect(0, -1, 8);
    chk("post_abort_ready", 64'(ready), 64'd1);
    start_key(k1, 1'b0);
    collect(0, -1, -1);

    // Parity bits do not influence the schedule
    ref_model(k6, 1'b0);
    start_key(k6, 1'b0);
    collect(0, -1, -1);
    for (int r = 0; r < 16; r++) saved[r] = got[r];
    ref_model(k6 ^ 64'h0101010101010101, 1'b0);
    start_key(k6 ^ 64'h0101010101010101, 1'b0);
    collect(0, -1, -1);
    for (int r = 0; r < 16; r++) chk($sformatf("parity_r%0d", r), 64'(got[r]), 64'(saved[r]));

    // Random keys and directions with random stalls
    for (int t = 0; t < 4; t++) begin
      rk = {$urandom, $urandom};
      rd = 1'($urandom_range(1));
      ref_model(rk, rd);
      start_key(rk, rd);
      collect(30, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
